// File: rtl/m_data_mem.sv
// m_data_mem: M-stage data memory for the five-stage MIPS pipeline.
// Stores (sw/sh/sb) commit on the rising edge. Loads (lw/lh/lhu/lb/lbu)
// are combinational reads of the current array contents.
// Optional build macro: DM_WRITE_LOG_EN prints one line per committed store.
module m_data_mem #(
    parameter int WORDS = 3072,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    output logic [31:0] rdata
);

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    // First byte address past the end of the array.
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * WORDS);

    // Word storage; cleared as a whole by reset, so it cannot map to a RAM macro.
    logic [31:0] mem_q [WORDS];

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic [31:0]      old_word;
    logic [3:0][7:0]  old_bytes;
    logic [15:0]      sel_half;
    logic [7:0]       sel_byte;
    logic [3:0]       byte_en;
    logic             wr_en;
    logic [31:0]      merged_word;

    assign word_idx  = addr[IDX_W+1:2];
    assign in_range  = (addr < BYTE_LIMIT);
    assign old_bytes = old_word;
    assign sel_half  = addr[1] ? old_word[31:16] : old_word[15:0];
    assign sel_byte  = old_bytes[addr[1:0]];

    // Current contents of the addressed word; zero when the address is off the end.
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem_q[word_idx];
        end
    end

    // Byte enables for the store; the reserved store type touches nothing.
    always_comb begin
        byte_en = 4'b0000;
        case (store_type)
            ST_SW:   byte_en = 4'b1111;
            ST_SH:   byte_en = addr[1] ? 4'b1100 : 4'b0011;
            ST_SB:   byte_en = 4'b0001 << addr[1:0];
            default: byte_en = 4'b0000;
        endcase
    end

    // A store commits only when enabled, in range and of a defined type.
    assign wr_en = mem_write && in_range && (byte_en != 4'b0000);

    // Per-lane merge: enabled lanes take store data, the rest keep the old byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] src_byte;

        // Halfword stores replicate wdata[15:0] into both halves; byte stores
        // replicate wdata[7:0] into all lanes; byte_en picks the real target.
        always_comb begin
            src_byte = wdata[8*gi +: 8];
            case (store_type)
                ST_SH:   src_byte = wdata[8*(gi%2) +: 8];
                ST_SB:   src_byte = wdata[7:0];
                default: src_byte = wdata[8*gi +: 8];
            endcase
        end

        assign merged_word[8*gi +: 8] = byte_en[gi] ? src_byte : old_bytes[gi];
    end

    // Array update: reset wipes every word and overrides a concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    // Load path: select and extend the addressed field; undefined types return 0.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            case (load_type)
                LD_LW:   rdata = old_word;
                LD_LH:   rdata = {{16{sel_half[15]}}, sel_half};
                LD_LHU:  rdata = {16'h0000, sel_half};
                LD_LB:   rdata = {{24{sel_byte[7]}}, sel_byte};
                LD_LBU:  rdata = {24'h000000, sel_byte};
                default: rdata = '0;
            endcase
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Store trace: one line per committed store showing the merged word.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_word);
        end
    end
`else
    // pc only feeds the store trace.
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_m_data_mem.sv
// tb_m_data_mem: directed test of m_data_mem with hand-computed expectations.
module tb_m_data_mem;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, SRSV = 2'b11;
    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010,
                           LB = 3'b011, LBU = 3'b100, LRSV = 3'b101;

    m_data_mem dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .addr       (addr),
        .wdata      (wdata),
        .mem_write  (mem_write),
        .store_type (store_type),
        .load_type  (load_type),
        .rdata      (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // One store committed at the next rising edge, then the enable is dropped.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
        @(negedge clk);
        pc = pc + 32'd4;
        addr = a; wdata = d; store_type = st; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] lt,
                            input logic [31:0] exp);
        @(negedge clk);
        addr = a; load_type = lt;
        #1;
        check_eq(tag, rdata, exp);
    endtask

    initial begin
        pc = 32'h0040_0000; addr = '0; wdata = '0; mem_write = 1'b0;
        store_type = SW; load_type = LW;

        // Single reset edge.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_chk("rst_lw_0000", 32'h0000_0000, LW, 32'h0000_0000);
        load_chk("rst_lw_2ffc", 32'h0000_2FFC, LW, 32'h0000_0000);

        // Word store/load, low address bits ignored by lw.
        store(32'h0000_0010, 32'hDEAD_BEEF, SW);
        load_chk("sw_lw_0010", 32'h0000_0010, LW, 32'hDEAD_BEEF);
        load_chk("sw_lw_0012", 32'h0000_0012, LW, 32'hDEAD_BEEF);

        // Byte and half merges with extended loads.
        store(32'h0000_0011, 32'h1234_5655, SB);
        load_chk("sb_merge", 32'h0000_0010, LW, 32'hDEAD_55EF);
        store(32'h0000_0013, 32'hABCD_8001, SH);
        load_chk("sh_merge", 32'h0000_0010, LW, 32'h8001_55EF);
        load_chk("lh_0012", 32'h0000_0012, LH, 32'hFFFF_8001);
        load_chk("lhu_0012", 32'h0000_0012, LHU, 32'h0000_8001);
        load_chk("lh_0011", 32'h0000_0011, LH, 32'h0000_55EF);
        load_chk("lb_0011", 32'h0000_0011, LB, 32'h0000_0055);
        load_chk("lbu_0010", 32'h0000_0010, LBU, 32'h0000_00EF);
        load_chk("lb_0010", 32'h0000_0010, LB, 32'hFFFF_FFEF);
        load_chk("lb_0013", 32'h0000_0013, LB, 32'hFFFF_FF80);
        load_chk("lbu_0012", 32'h0000_0012, LBU, 32'h0000_0001);
        load_chk("lrsv_0010", 32'h0000_0010, LRSV, 32'h0000_0000);

        // Reserved store type writes nothing.
        store(32'h0000_0010, 32'hFFFF_FFFF, SRSV);
        load_chk("srsv_nowr", 32'h0000_0010, LW, 32'h8001_55EF);

        // Same-cycle load and store to one word: old value before, new after.
        store(32'h0000_0020, 32'h1111_1111, SW);
        @(negedge clk);
        addr = 32'h0000_0020; load_type = LW;
        wdata = 32'h2222_2222; store_type = SW; mem_write = 1'b1;
        #1;
        check_eq("rw_same_pre", rdata, 32'h1111_1111);
        @(posedge clk);
        #1;
        check_eq("rw_same_post", rdata, 32'h2222_2222);
        @(negedge clk);
        mem_write = 1'b0;

        // Back-to-back stores on consecutive edges merge cumulatively.
        @(negedge clk);
        addr = 32'h0000_0030; wdata = 32'h0000_00AA; store_type = SB; mem_write = 1'b1;
        @(negedge clk);
        addr = 32'h0000_0031; wdata = 32'h0000_00BB; store_type = SB;
        @(negedge clk);
        addr = 32'h0000_0032; wdata = 32'h0000_CCDD; store_type = SH;
        @(negedge clk);
        mem_write = 1'b0;
        load_chk("b2b_merge", 32'h0000_0030, LW, 32'hCCDD_BBAA);

        // Range boundaries: last word usable, anything at or past 0x3000 dropped.
        store(32'h0000_0000, 32'h1234_5678, SW);
        store(32'h0000_2FFC, 32'hA5A5_5A5A, SW);
        load_chk("last_word", 32'h0000_2FFE, LHU, 32'h0000_A5A5);
        store(32'h0000_3000, 32'hFFFF_FFFF, SW);
        store(32'h0000_4000, 32'hFFFF_FFFF, SW);
        store(32'h8000_0000, 32'hFFFF_FFFF, SB);
        load_chk("oor_lw_3000", 32'h0000_3000, LW, 32'h0000_0000);
        load_chk("oor_lw_4000", 32'h0000_4000, LW, 32'h0000_0000);
        load_chk("oor_lbu_8000", 32'h8000_0000, LBU, 32'h0000_0000);
        load_chk("oor_keep_0000", 32'h0000_0000, LW, 32'h1234_5678);

        // Reset mid-stream: concurrent store discarded, all data cleared.
        @(negedge clk);
        addr = 32'h0000_0040; wdata = 32'hCAFE_F00D; store_type = SW;
        mem_write = 1'b1; reset = 1'b1;
        @(negedge clk);
        mem_write = 1'b0; reset = 1'b0;
        load_chk("rst_drop_0040", 32'h0000_0040, LW, 32'h0000_0000);
        load_chk("rst_clr_0010", 32'h0000_0010, LW, 32'h0000_0000);
        load_chk("rst_clr_0000", 32'h0000_0000, LW, 32'h0000_0000);
        load_chk("rst_clr_2ffc", 32'h0000_2FFC, LW, 32'h0000_0000);

        // First store after reset lands on the next edge.
        store(32'h0000_0044, 32'h0BAD_F00D, SW);
        load_chk("post_rst_sw", 32'h0000_0044, LW, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_data_mem.md
# m_data_mem

Data memory for the M stage of the five-stage MIPS pipeline. It consumes the M-register outputs (ALU result as byte address, forwarded rt value as store data, PC for logging) and performs word/half/byte stores on the clock edge and sign/zero-extended loads combinationally. Loaded data feeds the W pipeline register.

## Interface
Parameters:
- `WORDS`, 3072: number of 32-bit words; byte range 0x0000 to 4*WORDS-1.
- `IDX_W`, 12: word-index width; must satisfy 2^IDX_W >= WORDS.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  32  PC of the instruction in M; used only for the write log.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data; low bits used for half and byte stores.
- `mem_write`  in  1  store enable for this cycle.
- `store_type`  in  2  00 sw, 01 sh, 10 sb, 11 reserved (no write).
- `load_type`  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 return 0.
- `rdata`  out  32  extended load result.

## Operation
- Storage: `WORDS` x 32-bit array. Word index = `addr[IDX_W+1:2]`.
- In range when `addr < 4*WORDS`. Out-of-range stores are dropped; out-of-range loads return 0.
- Alignment: `addr[1:0]` is ignored for sw and lw. `addr[0]` is ignored for sh, lh, and lhu; `addr[1]` selects the half. For sb, lb, and lbu, `addr[1:0]` selects the byte. Little-endian: byte 0 is bits 7:0.
- Store merge:
  - sw replaces the whole word.
  - sh writes `wdata[15:0]` into the selected half.
  - sb writes `wdata[7:0]` into the selected byte.
  - Untouched bytes keep their old value.
- Load:
  - lw returns the whole word.
  - lh and lb sign-extend the selected field.
  - lhu and lbu zero-extend it.
- Reset: when `reset`=1 at a rising edge, every word is cleared to 0, and any store in that cycle is ignored.

## Timing
- Stores take effect at the rising edge where `mem_write`=1 and `reset`=0. The new value is visible on `rdata` right after that edge.
- Loads are combinational from the array and the current `addr`/`load_type`, with zero cycles of latency. A store and a load to the same word in the same cycle return the pre-store value.
- `rdata` reset value: 0 for every in-range address after the reset edge.
- Back-to-back stores to the same word on consecutive cycles: each one merges into the result of the previous one.
- Reset mid-stream: a reset edge discards the concurrent store and zeroes everything. The first store after reset deasserts lands on the next edge.

## Configuration
- `DM_WRITE_LOG_EN`:
  - Defined: on every committed store (including sh/sb), print one line at the same edge: `$display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word)`. `merged_word` is the full 32-bit word after merging. Dropped, out-of-range, and reset-cycle stores do not print.
  - Undefined: no simulation output; functional behaviour is identical.

## Test plan
- Reset then read: assert `reset` for 1 edge; lw at 0x0000 and at 0x2FFC -> `rdata`=0x00000000.
- Word store/load: sw `wdata`=0xDEADBEEF at 0x0010 -> next cycle, lw 0x0010 = 0xDEADBEEF; lw 0x0012 (low bits ignored) = 0xDEADBEEF; log line shows `*00000010 <= deadbeef`.
- Byte/half merge:
  - After the previous test, sb 0x55 at 0x0011 -> lw 0x0010 = 0xDEAD55EF.
  - Then sh 0x8001 at 0x0012 -> lw 0x0010 = 0x800155EF.
  - lh 0x0012 = 0xFFFF8001; lhu 0x0012 = 0x00008001.
  - lb 0x0011 = 0x00000055; lbu 0x0010 = 0x000000EF; lb 0x0010 = 0xFFFFFFEF.
- Same-cycle read/write: lw 0x0020 (holding 0x11111111) while sw 0x22222222 at 0x0020 -> `rdata`=0x11111111 in that cycle, 0x22222222 after the edge.
- Out of range:
  - sw 0xFFFFFFFF at 0x3000 -> no log line.
  - lw 0x3000 = 0; lw 0x0000 is unchanged.
- Reset mid-operation: sw 0xCAFEF00D at 0x0040 in the same cycle as `reset`=1 -> no log line; lw 0x0040 = 0, and all prior data is cleared.
